// File: rtl/bram_sdp_arb_pkg.sv
// Shared definitions for the simple-dual-port BRAM arbiter: requester limits,
// one-hot to index conversion and byte-lane width.
package bram_sdp_arb_pkg;

   localparam int MAX_REQ   = 4;
   localparam int MAX_IDX_W = $clog2(MAX_REQ);

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

   // x9 formats keep the parity bit inside its lane, so lanes are DATA/BE wide.
   function automatic int lane_width(input int dataWidth, input int beWidth);
      return dataWidth / beWidth;
   endfunction

endpackage

// File: rtl/bram_sdp_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer that moves just past the winner whenever advance_i is set.
module rr_arbiter
   import bram_sdp_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic                 advance_i,
   output logic [N-1:0]         gnt_o,
   output logic [MAX_IDX_W-1:0] ptr_o
);

   logic [MAX_IDX_W-1:0] ptr_q;
   logic [MAX_IDX_W-1:0] ptr_d;
   logic                 found;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      if (!rst_i) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (!found && (j == (int'(ptr_q) + i) % N) && req_i[j]) begin
                  found    = 1'b1;
                  gnt_o[j] = 1'b1;
                  if (advance_i) ptr_d = MAX_IDX_W'((j + 1) % N);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/bram_sdp_arbiter.sv
// Shares one simple-dual-port BRAM among NUM_REQ requesters with independent
// write/read round-robin arbiters. Optional macro BRAM_SDP_ARB_FWD_EN adds write-to-read forwarding.
module bram_sdp_arbiter
   import bram_sdp_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 36,
   parameter int BE_WIDTH   = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                             CLK_i,
   input  logic                             RST_i,
   input  logic [NUM_REQ-1:0]               WR_REQ_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    WR_ADDR_i,
   input  logic [NUM_REQ*BE_WIDTH-1:0]      WR_BE_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    WDATA_i,
   output logic [NUM_REQ-1:0]               WR_GNT_o,
   input  logic [NUM_REQ-1:0]               RD_REQ_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    RD_ADDR_i,
   output logic [NUM_REQ-1:0]               RD_GNT_o,
   output logic [NUM_REQ-1:0]               RVALID_o,
   output logic [DATA_WIDTH-1:0]            RDATA_o,
   output logic                             RAM_WEN_o,
   output logic [BE_WIDTH-1:0]              RAM_WR_BE_o,
   output logic [ADDR_WIDTH-1:0]            RAM_WR_ADDR_o,
   output logic [DATA_WIDTH-1:0]            RAM_WDATA_o,
   output logic                             RAM_REN_o,
   output logic [ADDR_WIDTH-1:0]            RAM_RD_ADDR_o,
   input  logic [DATA_WIDTH-1:0]            RAM_RDATA_i
);

   logic [NUM_REQ-1:0]    wrGnt, rdGnt;
   logic [MAX_REQ-1:0]    wrGntExt, rdGntExt;
   logic [MAX_IDX_W-1:0]  wrIdx, rdIdx;
   logic [ADDR_WIDTH-1:0] wrAddrSel, rdAddrSel;
   logic [BE_WIDTH-1:0]   wrBeSel;
   logic [DATA_WIDTH-1:0] wdataSel, rdataMerged;
   logic [NUM_REQ-1:0]    rdTag_q [RD_LAT+1];

   rr_arbiter #(.N(NUM_REQ)) u_wrArb (
      .clk_i(CLK_i), .rst_i(RST_i), .req_i(WR_REQ_i), .advance_i(1'b1),
      .gnt_o(wrGnt), .ptr_o()
   );

   rr_arbiter #(.N(NUM_REQ)) u_rdArb (
      .clk_i(CLK_i), .rst_i(RST_i), .req_i(RD_REQ_i), .advance_i(1'b1),
      .gnt_o(rdGnt), .ptr_o()
   );

   assign WR_GNT_o = wrGnt;
   assign RD_GNT_o = rdGnt;

   always_comb begin
      wrGntExt = '0;
      rdGntExt = '0;
      wrGntExt[NUM_REQ-1:0] = wrGnt;
      rdGntExt[NUM_REQ-1:0] = rdGnt;
      wrIdx     = onehot_to_idx(wrGntExt);
      rdIdx     = onehot_to_idx(rdGntExt);
      wrAddrSel = WR_ADDR_i[int'(wrIdx)*ADDR_WIDTH +: ADDR_WIDTH];
      wrBeSel   = WR_BE_i[int'(wrIdx)*BE_WIDTH +: BE_WIDTH];
      wdataSel  = WDATA_i[int'(wrIdx)*DATA_WIDTH +: DATA_WIDTH];
      rdAddrSel = RD_ADDR_i[int'(rdIdx)*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Without a grant the address/data registers hold; only the enables drop.
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         RAM_WEN_o     <= 1'b0;
         RAM_WR_BE_o   <= '0;
         RAM_WR_ADDR_o <= '0;
         RAM_WDATA_o   <= '0;
         RAM_REN_o     <= 1'b0;
         RAM_RD_ADDR_o <= '0;
      end else begin
         RAM_WEN_o <= |wrGnt;
         RAM_REN_o <= |rdGnt;
         if (|wrGnt) begin
            RAM_WR_BE_o   <= wrBeSel;
            RAM_WR_ADDR_o <= wrAddrSel;
            RAM_WDATA_o   <= wdataSel;
         end
         if (|rdGnt) RAM_RD_ADDR_o <= rdAddrSel;
      end
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         for (int i = 0; i <= RD_LAT; i++) rdTag_q[i] <= '0;
      end else begin
         rdTag_q[0] <= rdGnt;
         for (int i = 1; i <= RD_LAT; i++) rdTag_q[i] <= rdTag_q[i-1];
      end
   end

`ifdef BRAM_SDP_ARB_FWD_EN
   localparam int LANE_W = lane_width(DATA_WIDTH, BE_WIDTH);

   logic                  fwdHit;
   logic                  fwd_q     [RD_LAT+1];
   logic [BE_WIDTH-1:0]   fwdBe_q   [RD_LAT+1];
   logic [DATA_WIDTH-1:0] fwdData_q [RD_LAT+1];

   assign fwdHit = (|wrGnt) && (|rdGnt) && (wrAddrSel == rdAddrSel);

   // Forward payload rides alongside the read tag so it emerges with the RAM data.
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            fwd_q[i]     <= 1'b0;
            fwdBe_q[i]   <= '0;
            fwdData_q[i] <= '0;
         end
      end else begin
         fwd_q[0]     <= fwdHit;
         fwdBe_q[0]   <= wrBeSel;
         fwdData_q[0] <= wdataSel;
         for (int i = 1; i <= RD_LAT; i++) begin
            fwd_q[i]     <= fwd_q[i-1];
            fwdBe_q[i]   <= fwdBe_q[i-1];
            fwdData_q[i] <= fwdData_q[i-1];
         end
      end
   end

   always_comb begin
      rdataMerged = RAM_RDATA_i;
      for (int b = 0; b < BE_WIDTH; b++) begin
         if (fwd_q[RD_LAT] && fwdBe_q[RD_LAT][b])
            rdataMerged[b*LANE_W +: LANE_W] = fwdData_q[RD_LAT][b*LANE_W +: LANE_W];
      end
   end
`else
   assign rdataMerged = RAM_RDATA_i;
`endif

   assign RVALID_o = RST_i ? '0 : rdTag_q[RD_LAT];
   assign RDATA_o  = (|RVALID_o) ? rdataMerged : '0;

endmodule

// File: tb/tb_bram_sdp_arbiter.sv
// Self-checking bench for bram_sdp_arbiter: behavioural read-first RAM, a
// round-robin reference model and a read-return scoreboard queue.
module tb_bram_sdp_arbiter;

   localparam int NR = 2;
   localparam int AW = 10;
   localparam int DW = 36;
   localparam int BW = 4;
   localparam int LW = DW / BW;
   localparam int RL = 1;

   logic               CLK_i, RST_i;
   logic [NR-1:0]      WR_REQ_i, WR_GNT_o, RD_REQ_i, RD_GNT_o, RVALID_o;
   logic [NR*AW-1:0]   WR_ADDR_i, RD_ADDR_i;
   logic [NR*BW-1:0]   WR_BE_i;
   logic [NR*DW-1:0]   WDATA_i;
   logic [DW-1:0]      RDATA_o, RAM_WDATA_o, RAM_RDATA_i;
   logic               RAM_WEN_o, RAM_REN_o;
   logic [BW-1:0]      RAM_WR_BE_o;
   logic [AW-1:0]      RAM_WR_ADDR_o, RAM_RD_ADDR_o;

   bram_sdp_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RD_LAT(RL)) dut (
      .CLK_i(CLK_i), .RST_i(RST_i),
      .WR_REQ_i(WR_REQ_i), .WR_ADDR_i(WR_ADDR_i), .WR_BE_i(WR_BE_i), .WDATA_i(WDATA_i), .WR_GNT_o(WR_GNT_o),
      .RD_REQ_i(RD_REQ_i), .RD_ADDR_i(RD_ADDR_i), .RD_GNT_o(RD_GNT_o),
      .RVALID_o(RVALID_o), .RDATA_o(RDATA_o),
      .RAM_WEN_o(RAM_WEN_o), .RAM_WR_BE_o(RAM_WR_BE_o), .RAM_WR_ADDR_o(RAM_WR_ADDR_o), .RAM_WDATA_o(RAM_WDATA_o),
      .RAM_REN_o(RAM_REN_o), .RAM_RD_ADDR_o(RAM_RD_ADDR_o), .RAM_RDATA_i(RAM_RDATA_i)
   );

   initial begin
      CLK_i = 1'b0;
      forever #5 CLK_i = ~CLK_i;
   end

   // Behavioural read-first RAM with one cycle of read latency.
   logic [DW-1:0] mem [1 << AW];
   logic [DW-1:0] ramRd;
   logic          preloadEn;
   logic [DW-1:0] preloadVal;

   always @(posedge CLK_i) begin
      if (preloadEn) begin
         for (int a = 0; a < (1 << AW); a++) mem[a] <= preloadVal;
         ramRd <= '0;
      end else begin
         if (RAM_WEN_o)
            for (int b = 0; b < BW; b++)
               if (RAM_WR_BE_o[b]) mem[RAM_WR_ADDR_o][b*LW +: LW] <= RAM_WDATA_o[b*LW +: LW];
         if (RAM_REN_o) ramRd <= mem[RAM_RD_ADDR_o];
      end
   end
   assign RAM_RDATA_i = ramRd;

   typedef struct {
      int            due;
      logic [NR-1:0] tag;
      logic [DW-1:0] data;
   } sbEntry_t;

   sbEntry_t      sb[$];
   logic [DW-1:0] refMem [1 << AW];
   int            total, bad, cyc;
   int            wrPtrM, rdPtrM;
   logic          expWen, expRen;
   logic [BW-1:0] expWrBe;
   logic [AW-1:0] expWrAddr, expRdAddr;
   logic [DW-1:0] expWdata;

   function automatic logic [NR-1:0] rrPick(input logic [NR-1:0] req, input int ptr);
      logic [NR-1:0] one;
      one = 1;
      for (int i = 0; i < NR; i++) begin
         int j;
         j = (ptr + i) % NR;
         if (req[j]) return one << j;
      end
      return '0;
   endfunction

   function automatic int gntIdx(input logic [NR-1:0] gnt);
      for (int j = 0; j < NR; j++) if (gnt[j]) return j;
      return 0;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic setWr(input int k, input logic [AW-1:0] addr, input logic [BW-1:0] be, input logic [DW-1:0] data);
      WR_ADDR_i[k*AW +: AW] = addr;
      WR_BE_i[k*BW +: BW]   = be;
      WDATA_i[k*DW +: DW]   = data;
   endtask

   task automatic setRd(input int k, input logic [AW-1:0] addr);
      RD_ADDR_i[k*AW +: AW] = addr;
   endtask

   task automatic applyStimulus(input logic rst, input logic [NR-1:0] wrReq, input logic [NR-1:0] rdReq);
      RST_i    = rst;
      WR_REQ_i = wrReq;
      RD_REQ_i = rdReq;
   endtask

   // Checks the current cycle, advances the reference model, then steps one clock.
   task automatic checkOutput();
      logic [NR-1:0] eWg, eRg;
      sbEntry_t      e;
      int            k;
      #1;
      eWg = RST_i ? '0 : rrPick(WR_REQ_i, wrPtrM);
      eRg = RST_i ? '0 : rrPick(RD_REQ_i, rdPtrM);
      checkVal("wr_gnt", 64'(WR_GNT_o), 64'(eWg));
      checkVal("rd_gnt", 64'(RD_GNT_o), 64'(eRg));
      checkVal("ram_wen", 64'(RAM_WEN_o), 64'(expWen));
      checkVal("ram_wr_addr", 64'(RAM_WR_ADDR_o), 64'(expWrAddr));
      checkVal("ram_wr_be", 64'(RAM_WR_BE_o), 64'(expWrBe));
      checkVal("ram_wdata", 64'(RAM_WDATA_o), 64'(expWdata));
      checkVal("ram_ren", 64'(RAM_REN_o), 64'(expRen));
      checkVal("ram_rd_addr", 64'(RAM_RD_ADDR_o), 64'(expRdAddr));
      if (!RST_i && sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         checkVal("rvalid", 64'(RVALID_o), 64'(e.tag));
         checkVal("rdata", 64'(RDATA_o), 64'(e.data));
      end else begin
         checkVal("rvalid_idle", 64'(RVALID_o), 64'(0));
      end

      if (RST_i) begin
         wrPtrM = 0; rdPtrM = 0;
         expWen = 1'b0; expRen = 1'b0;
         expWrBe = '0; expWrAddr = '0; expWdata = '0; expRdAddr = '0;
         sb.delete();
      end else begin
         expWen = |eWg;
         expRen = |eRg;
         if (|eRg) begin
            k = gntIdx(eRg);
            expRdAddr = RD_ADDR_i[k*AW +: AW];
            e.due  = cyc + 1 + RL;
            e.tag  = eRg;
            e.data = refMem[expRdAddr];
`ifdef BRAM_SDP_ARB_FWD_EN
            if (|eWg && WR_ADDR_i[gntIdx(eWg)*AW +: AW] == expRdAddr)
               for (int b = 0; b < BW; b++)
                  if (WR_BE_i[gntIdx(eWg)*BW + b]) e.data[b*LW +: LW] = WDATA_i[gntIdx(eWg)*DW + b*LW +: LW];
`endif
            sb.push_back(e);
            rdPtrM = (k + 1) % NR;
         end
         if (|eWg) begin
            k = gntIdx(eWg);
            expWrAddr = WR_ADDR_i[k*AW +: AW];
            expWrBe   = WR_BE_i[k*BW +: BW];
            expWdata  = WDATA_i[k*DW +: DW];
            for (int b = 0; b < BW; b++)
               if (expWrBe[b]) refMem[expWrAddr][b*LW +: LW] = expWdata[b*LW +: LW];
            wrPtrM = (k + 1) % NR;
         end
      end
      @(posedge CLK_i);
      cyc++;
      @(negedge CLK_i);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      wrPtrM = 0; rdPtrM = 0;
      expWen = 1'b0; expRen = 1'b0;
      expWrBe = '0; expWrAddr = '0; expWdata = '0; expRdAddr = '0;
      WR_ADDR_i = '0; WR_BE_i = '0; WDATA_i = '0; RD_ADDR_i = '0;
      applyStimulus(1'b1, '0, '0);
      preloadVal = 36'hA5A5A5A5A;
      preloadEn  = 1'b1;
      for (int a = 0; a < (1 << AW); a++) refMem[a] = 36'hA5A5A5A5A;
      @(posedge CLK_i);
      @(posedge CLK_i);
      @(negedge CLK_i);
      preloadEn = 1'b0;

      // Reset holds grants off, then requester 0 wins first, requester 1 next.
      setWr(0, 10'h100, 4'hF, 36'h111111111);
      setWr(1, 10'h101, 4'hF, 36'h222222222);
      applyStimulus(1'b1, 2'b11, 2'b00); checkOutput();
      applyStimulus(1'b0, 2'b11, 2'b00); checkOutput();
      applyStimulus(1'b0, 2'b10, 2'b00); checkOutput();

      // Both readers contend for six cycles on preloaded data.
      setRd(0, 10'h010);
      setRd(1, 10'h020);
      for (int i = 0; i < 6; i++) begin applyStimulus(1'b0, 2'b00, 2'b11); checkOutput(); end
      for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end

      // Write from requester 1 to the top address, read back by requester 0.
      setWr(1, 10'h3FF, 4'hF, 36'h123456789);
      applyStimulus(1'b0, 2'b10, 2'b00); checkOutput();
      for (int i = 0; i < 2; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end
      setRd(0, 10'h3FF);
      applyStimulus(1'b0, 2'b00, 2'b01); checkOutput();
      for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end

      // Clear 0x005, then a same-cycle partial write and read of it.
      setWr(0, 10'h005, 4'hF, 36'h000000000);
      applyStimulus(1'b0, 2'b01, 2'b00); checkOutput();
      applyStimulus(1'b0, 2'b00, 2'b00); checkOutput();
      setWr(0, 10'h005, 4'h1, 36'hFFFFFFFFF);
      setRd(1, 10'h005);
      applyStimulus(1'b0, 2'b01, 2'b10); checkOutput();
      for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end

      // Reset pulsed while a read is in flight; pointers must restart at 0.
      setRd(0, 10'h010);
      setWr(0, 10'h200, 4'hF, 36'hABCDE0123);
      applyStimulus(1'b0, 2'b01, 2'b01); checkOutput();
      applyStimulus(1'b1, 2'b00, 2'b00); checkOutput();
      for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end
      applyStimulus(1'b0, 2'b11, 2'b11); checkOutput();
      for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end

      // Lone requester streams back-to-back reads and writes.
      for (int i = 0; i < 5; i++) begin
         setWr(0, AW'(10'h300 + i), 4'hF, DW'(36'h0F0F0F000 + i));
         setRd(0, AW'(10'h300 + i));
         applyStimulus(1'b0, 2'b01, 2'b01); checkOutput();
      end
      for (int i = 0; i < 4; i++) begin applyStimulus(1'b0, 2'b00, 2'b00); checkOutput(); end

      checkVal("sb_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
